// File: rtl/counter_x3.sv
// rtl/counter_x3.sv - three-channel programmable down-counter/timer (optional COUNTER_LATCH_EN read latch)
module counter_x3 #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             counter_we,
    input  logic [1:0]       counter_ch,
    input  logic [WIDTH-1:0] counter_val,
    output logic [WIDTH-1:0] counter_out,
    output logic             counter0_out,
    output logic             counter1_out,
    output logic             counter2_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RATE    = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    logic [PW-1:0]           presc_q, presc_d;
    logic                    tick;
    logic [11:0]             ctrl_q, ctrl_d;
    logic [2:0][WIDTH-1:0]   reload_q, reload_d;
    logic [2:0][WIDTH-1:0]   count_q, count_d;
    logic [2:0]              out_q, out_d;
    logic [2:0][1:0]         mode_old, mode_new;
    logic [2:0]              en_q;
    logic                    ctrl_wr;
    logic                    ctrl_apply;

    // Level seen right after a (re)load: square starts high, a zero-length one-shot fires immediately.
    function automatic logic init_out(input logic [1:0] mode, input logic [WIDTH-1:0] rl);
        return (mode == MODE_SQUARE) ||
               (((mode == MODE_ONESHOT) || (mode == MODE_RSVD)) && (rl == '0));
    endfunction

    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign ctrl_wr = counter_we && (counter_ch == 2'd3);

`ifdef COUNTER_LATCH_EN
    logic                  latch_cmd;
    logic                  latch_mode_q, latch_mode_d;
    logic [2:0][WIDTH-1:0] latch_q, latch_d;

    assign latch_cmd  = ctrl_wr && counter_val[WIDTH-1];
    assign ctrl_apply = ctrl_wr && !latch_cmd;

    always_comb begin
        latch_mode_d = latch_mode_q;
        latch_d      = latch_q;
        if (latch_cmd) begin
            latch_mode_d = 1'b1;
            latch_d      = count_q;
        end else if (ctrl_wr) begin
            latch_mode_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            latch_mode_q <= 1'b0;
            latch_q      <= '0;
        end else begin
            latch_mode_q <= latch_mode_d;
            latch_q      <= latch_d;
        end
    end
`else
    assign ctrl_apply = ctrl_wr;
`endif

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        ctrl_d  = ctrl_apply ? counter_val[11:0] : ctrl_q;
        for (int n = 0; n < 3; n++) begin
            mode_old[n] = ctrl_q[4*n+1 +: 2];
            mode_new[n] = ctrl_d[4*n+1 +: 2];
            en_q[n]     = ctrl_q[4*n];
        end
    end

    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        out_d    = out_q;
        for (int n = 0; n < 3; n++) begin
            // A rate pulse lasts one clk regardless of prescale or enable.
            if (mode_old[n] == MODE_RATE) begin
                out_d[n] = 1'b0;
            end
            if (counter_we && (counter_ch == 2'(n))) begin
                reload_d[n] = counter_val;
                count_d[n]  = counter_val;
                out_d[n]    = init_out(mode_old[n], counter_val);
            end else if (ctrl_apply && (mode_new[n] != mode_old[n])) begin
                count_d[n] = reload_q[n];
                out_d[n]   = init_out(mode_new[n], reload_q[n]);
            end else if (en_q[n] && tick && (count_q[n] == WIDTH'(1))) begin
                case (mode_old[n])
                    MODE_RATE: begin
                        count_d[n] = reload_q[n];
                        out_d[n]   = 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_d[n] = reload_q[n];
                        out_d[n]   = ~out_q[n];
                    end
                    default: begin
                        count_d[n] = '0;
                        out_d[n]   = 1'b1;
                    end
                endcase
            end else if (en_q[n] && tick && (count_q[n] > WIDTH'(1))) begin
                count_d[n] = count_q[n] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q  <= '0;
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        counter_out = '0;
        case (counter_ch)
            2'd3:    counter_out = WIDTH'(ctrl_q);
`ifdef COUNTER_LATCH_EN
            2'd0:    counter_out = latch_mode_q ? latch_q[0] : count_q[0];
            2'd1:    counter_out = latch_mode_q ? latch_q[1] : count_q[1];
            default: counter_out = latch_mode_q ? latch_q[2] : count_q[2];
`else
            2'd0:    counter_out = count_q[0];
            2'd1:    counter_out = count_q[1];
            default: counter_out = count_q[2];
`endif
        endcase
    end

    assign counter0_out = out_q[0];
    assign counter1_out = out_q[1];
    assign counter2_out = out_q[2];

endmodule
